// File: rtl/morse_char_scheduler.sv
// Keystroke queue between the PS/2 receiver and the Morse encoder: collects typed
// characters (with Backspace editing) and, on Enter, plays them out in order.
module morse_char_scheduler #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    ps2_received_data,
  input  logic          ps2_received_data_strb,
  output logic [7:0]    char_out,
  output logic          char_valid,
  input  logic          char_ready,
  output logic          playing,
  output logic [AW:0]   count,
  output logic          full,
  output logic          overflow
);

  typedef enum logic {S_COLLECT, S_PLAY} state_t;

  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0] CNT_ZERO = '0;

  state_t         r_state;
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [AW:0]    r_count;
  logic           r_skip;
  logic           r_overflow;
  logic [7:0]     r_mem [DEPTH];

  logic w_prefix, w_live, w_esc, w_enter, w_bksp, w_char, w_push;

  // A prefix byte always (re)arms the skip, so E0 F0 xx discards only xx.
  assign w_prefix = ps2_received_data_strb &&
                    (ps2_received_data == 8'hF0 || ps2_received_data == 8'hE0);
  assign w_live   = ps2_received_data_strb && !r_skip && !w_prefix;
  assign w_esc    = w_live && (ps2_received_data == 8'h76);
  assign w_enter  = w_live && (ps2_received_data == 8'h5A);
  assign w_bksp   = w_live && (ps2_received_data == 8'h66);
  assign w_char   = w_live && (ps2_received_data != 8'h00) && !ps2_received_data[7] &&
                    !w_esc && !w_enter && !w_bksp;
  assign w_push   = w_char && (r_state == S_COLLECT) && !full;

  assign playing    = (r_state == S_PLAY);
  assign char_valid = playing;
  assign char_out   = playing ? r_mem[r_rd_ptr] : 8'h00;
  assign count      = r_count;
  assign full       = (r_count == CNT_FULL);
  assign overflow   = r_overflow;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_COLLECT;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_skip     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (ps2_received_data_strb) r_skip <= w_prefix;

      if (w_esc) begin
        r_state    <= S_COLLECT;
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_count    <= '0;
        r_overflow <= 1'b0;
      end else begin
        case (r_state)
          S_COLLECT: begin
            if (w_push) begin
              r_wr_ptr <= r_wr_ptr + 1'b1;
              r_count  <= r_count + CNT_ONE;
            end else if (w_char) begin
              r_overflow <= 1'b1;
            end else if (w_bksp && r_count != CNT_ZERO) begin
              r_wr_ptr <= r_wr_ptr - 1'b1;
              r_count  <= r_count - CNT_ONE;
            end else if (w_enter && r_count != CNT_ZERO) begin
              r_state <= S_PLAY;
            end
          end
          S_PLAY: begin
            if (char_ready) begin
              r_rd_ptr <= r_rd_ptr + 1'b1;
              r_count  <= r_count - CNT_ONE;
              if (r_count == CNT_ONE) r_state <= S_COLLECT;
            end
          end
          default: r_state <= S_COLLECT;
        endcase
      end
    end
  end

  // NOTE: the queue RAM has no reset; an entry is only read after being written,
  // and leaving it unreset lets it map onto plain memory.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= ps2_received_data;
  end

endmodule

// File: tb/tb_morse_char_scheduler.sv
// Bench for morse_char_scheduler: a queue-based behavioural model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_morse_char_scheduler;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [7:0]    ps2_received_data = 8'h00;
  logic          ps2_received_data_strb = 1'b0;
  logic [7:0]    char_out;
  logic          char_valid;
  logic          char_ready = 1'b0;
  logic          playing;
  logic [AW:0]   count;
  logic          full;
  logic          overflow;

  int total = 0;
  int bad   = 0;

  morse_char_scheduler #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .ps2_received_data      (ps2_received_data),
    .ps2_received_data_strb (ps2_received_data_strb),
    .char_out               (char_out),
    .char_valid             (char_valid),
    .char_ready             (char_ready),
    .playing                (playing),
    .count                  (count),
    .full                   (full),
    .overflow               (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the queue is a SystemVerilog queue, the mode a single bit.
  byte unsigned m_q[$];
  bit m_play = 1'b0;
  bit m_skip = 1'b0;
  bit m_ovf  = 1'b0;

  task automatic model_step(input logic [7:0] d, input logic s, input logic r);
    bit act = 1'b0;
    bit esc = 1'b0;
    if (s) begin
      if (d == 8'hF0 || d == 8'hE0) m_skip = 1'b1;
      else if (m_skip)              m_skip = 1'b0;
      else begin
        act = 1'b1;
        esc = (d == 8'h76);
      end
    end
    if (esc) begin
      m_q.delete();
      m_play = 1'b0;
      m_ovf  = 1'b0;
    end else if (m_play) begin
      if (r) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) m_play = 1'b0;
      end
    end else if (act) begin
      if (d == 8'h5A) begin
        if (m_q.size() > 0) m_play = 1'b1;
      end else if (d == 8'h66) begin
        if (m_q.size() > 0) void'(m_q.pop_back());
      end else if (d != 8'h00 && d < 8'h80) begin
        if (m_q.size() == DEPTH) m_ovf = 1'b1;
        else m_q.push_back(d);
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_play = 1'b0;
      m_skip = 1'b0;
      m_ovf  = 1'b0;
    end else begin
      model_step(ps2_received_data, ps2_received_data_strb, char_ready);
    end
  end

  task automatic compare_all(input string tag);
    logic [7:0] exp_out;
    exp_out = m_play ? 8'(m_q[0]) : 8'h00;
    check({tag, "_playing"},  32'(playing),    32'(m_play));
    check({tag, "_valid"},    32'(char_valid), 32'(m_play));
    check({tag, "_char_out"}, 32'(char_out),   32'(exp_out));
    check({tag, "_count"},    32'(count),      32'(m_q.size()));
    check({tag, "_full"},     32'(full),       32'(m_q.size() == DEPTH));
    check({tag, "_overflow"}, 32'(overflow),   32'(m_ovf));
  endtask

  always @(negedge clk) compare_all("cyc");

  // Stimulus helpers: inputs change 1 time unit after an edge.
  task automatic send(input logic [7:0] b);
    @(negedge clk); #1;
    ps2_received_data      = b;
    ps2_received_data_strb = 1'b1;
    @(posedge clk); #1;
    ps2_received_data_strb = 1'b0;
  endtask

  task automatic set_ready(input logic v);
    @(negedge clk); #1;
    char_ready = v;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  byte unsigned cap[$];

  task automatic capture(input int max_cycles);
    cap.delete();
    for (int k = 0; k < max_cycles; k++) begin
      if (char_valid) cap.push_back(char_out);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    check("reset_playing", 32'(playing), 32'd0);
    check("reset_char_out", 32'(char_out), 32'd0);
    check("reset_count", 32'(count), 32'd0);
    #20 rst_n = 1'b1;

    // Basic play-out with the encoder always ready.
    char_ready = 1'b1;
    send(8'h1C); send(8'h29); send(8'h32); send(8'h5A);
    check("b1_playing_after_enter", 32'(playing), 32'd1);
    capture(6);
    check("b1_len", 32'(cap.size()), 32'd3);
    if (cap.size() == 3) begin
      check("b1_out0", 32'(cap[0]), 32'h1C);
      check("b1_out1", 32'(cap[1]), 32'h29);
      check("b1_out2", 32'(cap[2]), 32'h32);
    end
    check("b1_playing_end", 32'(playing), 32'd0);
    check("b1_count_end", 32'(count), 32'd0);

    // Prefix skipping, stalled encoder.
    set_ready(1'b0);
    send(8'h1C); send(8'hF0); send(8'h1C); send(8'h21); send(8'hE0); send(8'h5A);
    check("b2_not_playing", 32'(playing), 32'd0);
    check("b2_count", 32'(count), 32'd2);
    send(8'h5A);
    check("b2_playing", 32'(playing), 32'd1);
    idle(3);
    check("b2_held_out", 32'(char_out), 32'h1C);
    check("b2_held_valid", 32'(char_valid), 32'd1);
    set_ready(1'b1);
    capture(4);
    check("b2_len", 32'(cap.size()), 32'd2);
    if (cap.size() == 2) begin
      check("b2_out0", 32'(cap[0]), 32'h1C);
      check("b2_out1", 32'(cap[1]), 32'h21);
    end

    // Fill to full (write pointer wraps), overflow, Escape.
    for (int i = 0; i < DEPTH; i++) send(8'(8'h10 + i));
    check("b3_full", 32'(full), 32'd1);
    check("b3_count16", 32'(count), 32'd16);
    check("b3_no_ovf_yet", 32'(overflow), 32'd0);
    send(8'h20);
    check("b3_ovf", 32'(overflow), 32'd1);
    check("b3_count_still16", 32'(count), 32'd16);
    send(8'h76);
    check("b3_esc_count", 32'(count), 32'd0);
    check("b3_esc_ovf", 32'(overflow), 32'd0);
    check("b3_esc_full", 32'(full), 32'd0);

    // Backspace editing.
    send(8'h1C); send(8'h32); send(8'h66); send(8'h21);
    check("b4_count", 32'(count), 32'd2);
    send(8'h5A);
    capture(4);
    check("b4_len", 32'(cap.size()), 32'd2);
    if (cap.size() == 2) begin
      check("b4_out0", 32'(cap[0]), 32'h1C);
      check("b4_out1", 32'(cap[1]), 32'h21);
    end
    send(8'h66);
    check("b4_bksp_empty", 32'(count), 32'd0);
    send(8'h33); send(8'h5A);
    capture(3);
    check("b4_after_len", 32'(cap.size()), 32'd1);
    if (cap.size() == 1) check("b4_after_out", 32'(cap[0]), 32'h33);

    // Bytes ignored in PLAY, then Escape coinciding with a pop.
    set_ready(1'b0);
    send(8'h11); send(8'h22); send(8'h33); send(8'h5A);
    check("b5_playing", 32'(playing), 32'd1);
    send(8'h1C);
    check("b5_ignored_count", 32'(count), 32'd3);
    check("b5_head", 32'(char_out), 32'h11);
    @(negedge clk); #1;
    char_ready             = 1'b1;
    ps2_received_data      = 8'h76;
    ps2_received_data_strb = 1'b1;
    @(posedge clk); #1;
    ps2_received_data_strb = 1'b0;
    char_ready             = 1'b0;
    check("b5_esc_valid", 32'(char_valid), 32'd0);
    check("b5_esc_count", 32'(count), 32'd0);
    check("b5_esc_playing", 32'(playing), 32'd0);
    idle(2);
    check("b5_still_idle", 32'(char_valid), 32'd0);

    // Asynchronous reset mid-PLAY.
    send(8'h44); send(8'h45); send(8'h5A);
    check("b6_playing", 32'(playing), 32'd1);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("b6_rst_playing", 32'(playing), 32'd0);
    check("b6_rst_valid", 32'(char_valid), 32'd0);
    check("b6_rst_out", 32'(char_out), 32'd0);
    check("b6_rst_count", 32'(count), 32'd0);
    check("b6_rst_full", 32'(full), 32'd0);
    check("b6_rst_ovf", 32'(overflow), 32'd0);
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b1;
    send(8'h5A);
    for (int k = 0; k < 3; k++) begin
      check("b6_no_valid", 32'(char_valid), 32'd0);
      idle(1);
    end

    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/morse_char_scheduler.md
MORSE_CHAR_SCHEDULER -- requirements
Module: morse_char_scheduler

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning number of queued scancodes (power of two, 2..64).
REQ-002 SHALL have parameter AW, default 4, meaning log2(DEPTH) pointer width.
REQ-003 SHALL have port clk  input  1  system clock (50 MHz); all logic rising-edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port ps2_received_data  input  8  scancode byte from ps2_controller.
REQ-006 SHALL have port ps2_received_data_strb  input  1  one-cycle strobe, byte valid.
REQ-007 SHALL have port char_out  output  8  head-of-queue scancode offered to morse_code_encoder.
REQ-008 SHALL have port char_valid  output  1  char_out valid.
REQ-009 SHALL have port char_ready  input  1  encoder accepts char_out this cycle.
REQ-010 SHALL have port playing  output  1  high in PLAY state.
REQ-011 SHALL have port count  output  AW+1  entries queued.
REQ-012 SHALL have port full  output  1  count == DEPTH.
REQ-013 SHALL have port overflow  output  1  sticky, keystroke dropped while full.

Function
REQ-014 SHALL classify each strobed byte: 0xF0 = break prefix, 0xE0 = extended prefix, 0x5A = Enter, 0x66 = Backspace, 0x76 = Escape; other 0x01..0x7F = character; 0x00 and other 0x80..0xFF = discard.
REQ-015 SHALL set a skip flag on 0xF0 or 0xE0 and discard the next strobed byte (any value, including controls), then clear the flag; consecutive prefixes (E0 F0 xx) SHALL skip only xx.
REQ-016 SHALL implement two states, COLLECT (reset state) and PLAY.
REQ-017 In COLLECT, a character byte SHALL be written at the tail; count increments the cycle after the strobe.
REQ-018 In COLLECT with full=1, a character byte SHALL be dropped and overflow set to 1; count unchanged.
REQ-019 In COLLECT, Backspace SHALL remove the most recently written entry (tail-1); no-op when count == 0.
REQ-020 In COLLECT, Enter with count > 0 SHALL move to PLAY; with count == 0 SHALL be ignored.
REQ-021 In PLAY, char_valid SHALL be 1 and char_out SHALL equal the oldest entry, held stable until char_valid && char_ready.
REQ-022 On char_valid && char_ready, the head SHALL be popped; next entry presented the following cycle (no bubble beyond one cycle); popping the last entry SHALL return to COLLECT with char_valid=0 the next cycle.
REQ-023 Enter strobe in cycle N SHALL give playing=1, char_valid=1 in cycle N+1.
REQ-024 In PLAY, character, Enter and Backspace bytes SHALL be ignored (not queued); prefix skipping still applies.
REQ-025 Escape in either state SHALL empty the queue (count=0), clear overflow, drop char_valid and enter COLLECT the next cycle.
REQ-026 Escape coinciding with a pop SHALL win: queue empty afterwards, no further char_valid.
REQ-027 Pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH nor underflow below 0.
REQ-028 char_out SHALL be 0x00 whenever char_valid=0.

Reset
REQ-029 rst_n=0 SHALL asynchronously force: state COLLECT, pointers 0, count 0, skip flag 0, overflow 0, char_valid 0, char_out 0x00, playing 0, full 0.
REQ-030 Reset asserted mid-PLAY SHALL abandon the queue; no char_valid after release until a new Enter.
REQ-031 Queue storage contents need no reset.

Verification
REQ-032 Strobe 1C, 29, 32, 5A; char_ready=1 -> char_valid for 3 cycles with char_out 1C, 29, 32; then playing=0, count=0.
REQ-033 Strobe 1C, F0, 1C, 21, E0, 5A, 5A with char_ready=0 -> count=2 (1C, 21); enter PLAY once; char_out=1C held stable until char_ready=1.
REQ-034 Strobe 17 distinct characters with DEPTH=16 -> full=1 after 16th, overflow=1 after 17th, count=16; Escape -> count=0, overflow=0.
REQ-035 Strobe 1C, 32, 66, 21, 5A -> output sequence 1C, 21; Backspace with count=0 -> count stays 0.
REQ-036 In PLAY with 3 queued, strobe 1C (ignored, count unchanged), then 76 in the same cycle as a pop -> char_valid=0, count=0, playing=0 next cycle.
REQ-037 Assert rst_n=0 asynchronously between clock edges during PLAY -> all outputs at reset values immediately; after release, 5A alone -> no char_valid.
